// File: rtl/theta_to_vector_rotator.sv
// theta_to_vector_rotator
// Rebuilds an N_DIM-element vector w from N_DIM-1 hyperspherical angles and a
// magnitude by issuing N_DIM-1 sequential rotations to a shared external
// CORDIC rotation core. Rotation k turns (cur, 0) by theta[k], walking from
// k = N_DIM-2 down to 0; the y result feeds the next rotation and the x
// result becomes w[k+1]. The last rotation yields w[0] and w[1].
//
// Optional build macro: THETA_ZERO_SKIP_EN
//   When defined, a zero angle bypasses the core. The rotation result is taken
//   as (cur, 0) in the issue cycle, which saves 1+L cycles per zero angle.
//   When undefined, every angle is sent through the core.
module theta_to_vector_rotator #(
    parameter int DATA_WIDTH  = 16,
    parameter int ANGLE_WIDTH = 16,
    parameter int N_DIM       = 7
) (
    input  logic                             clk,
    input  logic                             nreset,
    input  logic                             start,
    input  logic [(N_DIM-1)*ANGLE_WIDTH-1:0] theta_in_flat,
    input  logic [DATA_WIDTH-1:0]            r_in,
    input  logic [DATA_WIDTH-1:0]            cordic_xout,
    input  logic [DATA_WIDTH-1:0]            cordic_yout,
    input  logic                             cordic_op_vld,
    output logic                             cordic_nrst,
    output logic                             cordic_en,
    output logic [DATA_WIDTH-1:0]            cordic_xin,
    output logic [DATA_WIDTH-1:0]            cordic_yin,
    output logic [ANGLE_WIDTH-1:0]           cordic_angle_in,
    output logic [N_DIM*DATA_WIDTH-1:0]      w_out_flat,
    output logic                             busy,
    output logic                             done
);

    // Rotation index width; at least one bit even for the smallest legal N_DIM.
    localparam int K_W = ($clog2(N_DIM-1) > 1) ? $clog2(N_DIM-1) : 1;
    localparam logic [K_W-1:0] K_INIT = K_W'(N_DIM-2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                 state;
    logic [K_W-1:0]         k;
    logic [DATA_WIDTH-1:0]  cur;
    logic [ANGLE_WIDTH-1:0] theta_q [N_DIM-1];
    logic [DATA_WIDTH-1:0]  w_work  [N_DIM];

    // Rotation result for the current step and whether it is taken this cycle.
    logic                   take;
    logic                   last;
    logic [DATA_WIDTH-1:0]  res_x;
    logic [DATA_WIDTH-1:0]  res_y;

    // The core never rotates y here, so its y input is a constant zero.
    assign cordic_yin = '0;

    // Select where the rotation result comes from and when it is consumed.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned, which would infer a latch.
        take  = 1'b0;
        res_x = cordic_xout;
        res_y = cordic_yout;
        last  = (k == '0);
        if (state == S_WAIT && cordic_op_vld) begin
            take = 1'b1;
        end
`ifdef THETA_ZERO_SKIP_EN
        // A zero-angle rotation is the identity: (cur, 0) stays (cur, 0).
        if (state == S_ISSUE && theta_q[k] == '0) begin
            take  = 1'b1;
            res_x = cur;
            res_y = '0;
        end
`endif
    end

    // Sequencer: latches the request, drives the core, collects results, publishes w.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state           <= S_IDLE;
            k               <= '0;
            cur             <= '0;
            cordic_nrst     <= 1'b0;
            cordic_en       <= 1'b0;
            cordic_xin      <= '0;
            cordic_angle_in <= '0;
            w_out_flat      <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            // NOTE: the angle copy and work vector are small register arrays, not RAM, so they are cleared with everything else.
            for (int j = 0; j < N_DIM-1; j++) begin
                theta_q[j] <= '0;
            end
            for (int i = 0; i < N_DIM; i++) begin
                w_work[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments throughout, so every register sees pre-edge values of the others.
            done <= 1'b0;
            if (take) begin
                // Store the rotation result and release the core for at least one cycle.
                for (int i = 0; i < N_DIM; i++) begin
                    if (last) begin
                        if (i == 0) w_work[i] <= res_x;
                        if (i == 1) w_work[i] <= res_y;
                    end else if (i == int'(k) + 1) begin
                        w_work[i] <= res_x;
                    end
                end
                if (!last) begin
                    cur <= res_y;
                end
                cordic_nrst <= 1'b0;
                cordic_en   <= 1'b0;
                if (last) begin
                    state <= S_DONE;
                end else begin
                    k     <= k - 1'b1;
                    state <= S_ISSUE;
                end
            end else begin
                case (state)
                    S_IDLE: begin
                        cordic_nrst <= 1'b0;
                        cordic_en   <= 1'b0;
                        if (start) begin
                            for (int j = 0; j < N_DIM-1; j++) begin
                                theta_q[j] <= theta_in_flat[j*ANGLE_WIDTH +: ANGLE_WIDTH];
                            end
                            cur   <= r_in;
                            k     <= K_INIT;
                            busy  <= 1'b1;
                            state <= S_ISSUE;
                        end
                    end
                    S_ISSUE: begin
                        cordic_nrst     <= 1'b1;
                        cordic_en       <= 1'b1;
                        cordic_xin      <= cur;
                        cordic_angle_in <= theta_q[k];
                        state           <= S_WAIT;
                    end
                    S_WAIT: begin
                        // Core inputs are held until the result is valid.
                    end
                    S_DONE: begin
                        for (int i = 0; i < N_DIM; i++) begin
                            w_out_flat[i*DATA_WIDTH +: DATA_WIDTH] <= w_work[i];
                        end
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_theta_to_vector_rotator.sv
// tb_theta_to_vector_rotator
// Scoreboard bench for theta_to_vector_rotator with N_DIM=3 and an ideal
// gain-compensated rotation core model of latency L=4. Expected core issues
// and w results are pushed when a request is driven and popped when the DUT
// raises cordic_en or done. Honours THETA_ZERO_SKIP_EN like the design.
module tb_theta_to_vector_rotator;

    localparam int  DW = 16;
    localparam int  AW = 16;
    localparam int  N  = 3;
    localparam int  L  = 4;
    localparam real PI = 3.14159265358979;
`ifdef THETA_ZERO_SKIP_EN
    localparam bit  SKIP = 1'b1;
`else
    localparam bit  SKIP = 1'b0;
`endif

    logic                clk;
    logic                nreset;
    logic                start;
    logic [(N-1)*AW-1:0] theta_in_flat;
    logic [DW-1:0]       r_in;
    logic [DW-1:0]       cordic_xout;
    logic [DW-1:0]       cordic_yout;
    logic                cordic_op_vld;
    logic                cordic_nrst;
    logic                cordic_en;
    logic [DW-1:0]       cordic_xin;
    logic [DW-1:0]       cordic_yin;
    logic [AW-1:0]       cordic_angle_in;
    logic [N*DW-1:0]     w_out_flat;
    logic                busy;
    logic                done;

    theta_to_vector_rotator #(
        .DATA_WIDTH  (DW),
        .ANGLE_WIDTH (AW),
        .N_DIM       (N)
    ) dut (
        .clk             (clk),
        .nreset          (nreset),
        .start           (start),
        .theta_in_flat   (theta_in_flat),
        .r_in            (r_in),
        .cordic_xout     (cordic_xout),
        .cordic_yout     (cordic_yout),
        .cordic_op_vld   (cordic_op_vld),
        .cordic_nrst     (cordic_nrst),
        .cordic_en       (cordic_en),
        .cordic_xin      (cordic_xin),
        .cordic_yin      (cordic_yin),
        .cordic_angle_in (cordic_angle_in),
        .w_out_flat      (w_out_flat),
        .busy            (busy),
        .done            (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input longint obs, input longint exp, input longint tol = 0);
        longint d;
        checks++;
        d = obs - exp;
        if (d < 0) d = -d;
        if (d > tol) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, obs, exp, tol);
        end
    endtask

    function automatic longint s16(input logic [DW-1:0] v);
        return longint'($signed(v));
    endfunction

    function automatic logic [DW-1:0] rnd(input real v);
        int iv;
        iv = $rtoi((v >= 0.0) ? v + 0.5 : v - 0.5);
        return iv[DW-1:0];
    endfunction

    function automatic real rad(input logic [AW-1:0] a);
        return $itor($signed(a)) * PI / 2.0 / $itor(1 << (AW-2));
    endfunction

    function automatic logic [DW-1:0] rot_x(input logic [DW-1:0] x, input logic [AW-1:0] a);
        return rnd($itor($signed(x)) * $cos(rad(a)));
    endfunction

    function automatic logic [DW-1:0] rot_y(input logic [DW-1:0] x, input logic [AW-1:0] a);
        return rnd($itor($signed(x)) * $sin(rad(a)));
    endfunction

    // Ideal rotation core: valid L cycles after it first samples en, cleared by en or nrst low.
    logic          spur = 1'b0;
    logic          c_vld = 1'b0;
    logic [DW-1:0] c_x = '0;
    logic [DW-1:0] c_y = '0;
    int            c_cnt = 0;
    assign cordic_op_vld = c_vld | spur;
    assign cordic_xout   = c_x;
    assign cordic_yout   = c_y;

    always @(posedge clk) begin
        if (!cordic_nrst || !cordic_en) begin
            c_cnt <= 0;
            c_vld <= 1'b0;
        end else begin
            if (c_cnt < L) c_cnt <= c_cnt + 1;
            if (c_cnt == L-1) begin
                c_vld <= 1'b1;
                c_x   <= rot_x(cordic_xin, cordic_angle_in);
                c_y   <= rot_y(cordic_xin, cordic_angle_in);
            end
        end
    end

    typedef struct packed {
        logic [DW-1:0] xin;
        logic [AW-1:0] ang;
    } iss_t;

    iss_t            iss_q[$];
    logic [N*DW-1:0] sb_q[$];

    int              issues = 0;
    int              dones = 0;
    int              wout_viol = 0;
    logic            en_prev = 1'b0;
    logic [N*DW-1:0] w_prev = '0;

    // Output monitor: pops expected core issues and results, watches w_out stability.
    always @(negedge clk) begin
        iss_t            e;
        logic [N*DW-1:0] w;
        if (!nreset) begin
            en_prev = 1'b0;
            w_prev  = w_out_flat;
        end else begin
            if (cordic_en && !en_prev) begin
                issues++;
                if (iss_q.size() == 0) begin
                    check("issue_unexpected", 1, 0);
                end else begin
                    e = iss_q.pop_front();
                    check("issue_xin", s16(cordic_xin), s16(e.xin));
                    check("issue_angle", s16(cordic_angle_in), s16(e.ang));
                    check("issue_yin", s16(cordic_yin), 0);
                end
            end
            en_prev = cordic_en;
            if (done) begin
                dones++;
                if (sb_q.size() == 0) begin
                    check("done_unexpected", 1, 0);
                end else begin
                    w = sb_q.pop_front();
                    for (int i = 0; i < N; i++) begin
                        check($sformatf("w%0d", i), s16(w_out_flat[i*DW +: DW]), s16(w[i*DW +: DW]));
                    end
                end
            end else if (w_out_flat != w_prev) begin
                wout_viol++;
            end
            w_prev = w_out_flat;
        end
    end

    // Reference model of one request: queues expected issues and result, returns latency.
    task automatic push_expect(input logic [DW-1:0] r, input logic [(N-1)*AW-1:0] th, output int lat);
        logic [DW-1:0]   cur;
        logic [DW-1:0]   x;
        logic [DW-1:0]   y;
        logic [AW-1:0]   a;
        logic [N*DW-1:0] w;
        iss_t            e;
        cur = r;
        w   = '0;
        lat = 1;
        for (int k = N-2; k >= 0; k--) begin
            a = th[k*AW +: AW];
            if (SKIP && a == '0) begin
                x   = cur;
                y   = '0;
                lat += 1;
            end else begin
                e.xin = cur;
                e.ang = a;
                iss_q.push_back(e);
                x   = rot_x(cur, a);
                y   = rot_y(cur, a);
                lat += 2 + L;
            end
            if (k > 0) begin
                w[(k+1)*DW +: DW] = x;
                cur = y;
            end else begin
                w[0 +: DW]  = x;
                w[DW +: DW] = y;
            end
        end
        sb_q.push_back(w);
    endtask

    task automatic run_op(input string tag, input logic [DW-1:0] r, input logic [AW-1:0] th1,
                          input logic [AW-1:0] th0, input int dup_at, input bit dup_done);
        int exp_lat;
        int lat;
        int busy_low;
        int d0;
        bit seen;
        theta_in_flat = {th1, th0};
        r_in          = r;
        push_expect(r, {th1, th0}, exp_lat);
        d0 = dones;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        // Scramble the request inputs to show the block works from its own copy.
        theta_in_flat = ~theta_in_flat;
        r_in          = ~r_in;
        seen     = 1'b0;
        lat      = 0;
        busy_low = 0;
        for (int n = 1; n <= 400 && !seen; n++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (done) begin
                seen = 1'b1;
                lat  = n;
            end else begin
                if (!busy) busy_low++;
                if (n == dup_at || (dup_done && n == exp_lat - 1)) start = 1'b1;
            end
        end
        start = 1'b0;
        check({tag, "_timeout"}, longint'(seen), 1);
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_busy_during"}, busy_low, 0);
        check({tag, "_busy_at_done"}, longint'(busy), 0);
        repeat (20) @(posedge clk);
        #1;
        check({tag, "_done_count"}, dones - d0, 1);
        check({tag, "_idle_busy"}, longint'(busy), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int i0;
        int d0;
        int lat;
        bit seen;
        logic [DW-1:0] rr;
        logic [AW-1:0] t1;
        logic [AW-1:0] t0;

        start         = 1'b0;
        theta_in_flat = '0;
        r_in          = '0;
        nreset        = 1'b1;
        #2 nreset = 1'b0;
        #1;
        check("rst_busy", longint'(busy), 0);
        check("rst_done", longint'(done), 0);
        check("rst_w_out", longint'(w_out_flat), 0);
        check("rst_cordic_nrst", longint'(cordic_nrst), 0);
        check("rst_cordic_en", longint'(cordic_en), 0);
        check("rst_cordic_xin", longint'(cordic_xin), 0);
        check("rst_cordic_angle", longint'(cordic_angle_in), 0);
        repeat (3) @(posedge clk);
        #1 nreset = 1'b1;
        repeat (2) @(posedge clk);

        // Zero angles: with the skip option the core is never started.
        i0 = issues;
        run_op("s1", 16'h4000, 16'h0000, 16'h0000, -1, 1'b0);
        check("s1_issue_count", issues - i0, SKIP ? 0 : 2);
        check("s1_w0", s16(w_out_flat[0 +: DW]), 0);
        check("s1_w1", s16(w_out_flat[DW +: DW]), 0);
        check("s1_w2", s16(w_out_flat[2*DW +: DW]), 16'h4000);

        // 90 degrees then 0.
        run_op("s2", 16'h4000, 16'h4000, 16'h0000, -1, 1'b0);
        check("s2_w0", s16(w_out_flat[0 +: DW]), 16'h4000, 1);
        check("s2_w1", s16(w_out_flat[DW +: DW]), 0, 1);
        check("s2_w2", s16(w_out_flat[2*DW +: DW]), 0, 1);

        // 45 degrees twice.
        run_op("s3", 16'h2000, 16'h2000, 16'h2000, -1, 1'b0);
        check("s3_w0", s16(w_out_flat[0 +: DW]), 16'h1000, 2);
        check("s3_w1", s16(w_out_flat[DW +: DW]), 16'h1000, 2);
        check("s3_w2", s16(w_out_flat[2*DW +: DW]), 16'h16A1, 2);

        // Extra start pulses while busy and in the S_DONE cycle are ignored.
        run_op("s4", 16'h3000, 16'hC000, 16'h1000, 4, 1'b1);

        // A few random requests, including negative magnitudes and angles.
        for (int n = 0; n < 4; n++) begin
            rr = DW'($urandom_range(0, 16'h6000)) - 16'h3000;
            t1 = AW'($urandom);
            t0 = (n == 1) ? 16'h0000 : AW'($urandom);
            run_op($sformatf("rand%0d", n), rr, t1, t0, -1, 1'b0);
        end

        // A core valid outside S_WAIT must not disturb the idle block.
        d0 = dones;
        @(posedge clk); #1 spur = 1'b1;
        repeat (3) @(posedge clk);
        #1 spur = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("spur_done", dones - d0, 0);
        check("spur_busy", longint'(busy), 0);
        check("spur_en", longint'(cordic_en), 0);

        // Reset during the second S_WAIT aborts the request.
        d0 = dones;
        i0 = issues;
        theta_in_flat = {16'h2000, 16'h2000};
        r_in          = 16'h2000;
        push_expect(16'h2000, {16'h2000, 16'h2000}, lat);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 200 && !seen; n++) begin
            @(posedge clk); #1;
            if (issues - i0 >= 2) seen = 1'b1;
        end
        check("s5_second_issue_timeout", longint'(seen), 1);
        repeat (2) @(posedge clk);
        #1 nreset = 1'b0;
        #1;
        check("s5_busy", longint'(busy), 0);
        check("s5_done", longint'(done), 0);
        check("s5_w_out", longint'(w_out_flat), 0);
        check("s5_cordic_en", longint'(cordic_en), 0);
        check("s5_cordic_nrst", longint'(cordic_nrst), 0);
        check("s5_cordic_xin", longint'(cordic_xin), 0);
        check("s5_cordic_angle", longint'(cordic_angle_in), 0);
        repeat (2) @(posedge clk);
        sb_q.delete();
        iss_q.delete();
        #1 nreset = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check("s5_no_done", dones - d0, 0);
        run_op("s5_after", 16'h4000, 16'h4000, 16'h0000, -1, 1'b0);
        check("s5_after_w0", s16(w_out_flat[0 +: DW]), 16'h4000, 1);

        check("sb_left", sb_q.size(), 0);
        check("iss_left", iss_q.size(), 0);
        check("w_out_stable", wout_viol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/theta_to_vector_rotator.md
Name: theta_to_vector_rotator

Overview:
- Inverse of the hyperspherical angle extractor in the FastICA datapath.
- Takes N_DIM-1 angles and a magnitude, and rebuilds the N_DIM-element vector w.
- Issues N_DIM-1 sequential rotations to one shared external CORDIC rotation core through a nrst/en/valid handshake.
- Sits after the theta-domain update, feeding reconstructed w back to the projection and whitening stages.

Parameters:
- DATA_WIDTH, 16, width of each vector element and of the magnitude.
- ANGLE_WIDTH, 16, width of each angle. Units are those of the rotation core; the bench uses binary angle, 2^(ANGLE_WIDTH-2) = +90 deg.
- N_DIM, 7, vector dimension. Legal range N_DIM >= 3.

Ports:
- clk  in  1  clock.
- nreset  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request. Sampled only in S_IDLE.
- theta_in_flat  in  (N_DIM-1)*ANGLE_WIDTH  angle k in bits [(k+1)*ANGLE_WIDTH-1 -: ANGLE_WIDTH].
- r_in  in  DATA_WIDTH  signed magnitude, the final vectoring x output.
- cordic_xout  in  DATA_WIDTH  signed rotated x, gain-compensated by the core.
- cordic_yout  in  DATA_WIDTH  signed rotated y, gain-compensated by the core.
- cordic_op_vld  in  1  core result valid.
- cordic_nrst  out  1  core soft reset. 0 = core held in reset.
- cordic_en  out  1  core rotation enable.
- cordic_xin  out  DATA_WIDTH  signed rotation input x.
- cordic_yin  out  DATA_WIDTH  signed rotation input y. Always 0 in this block.
- cordic_angle_in  out  ANGLE_WIDTH  signed rotation angle.
- w_out_flat  out  N_DIM*DATA_WIDTH  element i in bits [(i+1)*DATA_WIDTH-1 -: DATA_WIDTH].
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when w_out_flat is updated.

Behaviour:
- Reset is asynchronous, nreset=0. All outputs go to 0, including w_out_flat, done, busy and cordic_nrst. State goes to S_IDLE. Internal registers (angle copy, cur, k, w_work) are cleared.
- Reset asserted mid-operation aborts the sequence immediately. No done pulse is produced. w_out_flat is cleared.
- Math, per rotation k, iterated from k = N_DIM-2 down to 0:
  - Rotate (cur, 0) by theta[k]. Initial cur = r_in.
  - For k > 0: w[k+1] = xout, cur = yout.
  - For k = 0: w[0] = xout, w[1] = yout.
- Counter k is max(1, $clog2(N_DIM-1)) bits wide.
- S_IDLE:
  - On start, latch theta_in_flat and r_in, set k = N_DIM-2, set busy=1, go to S_ISSUE.
  - Otherwise hold all outputs. cordic_en=0, cordic_nrst=0.
- S_ISSUE, one cycle:
  - Registered outputs: cordic_nrst=1, cordic_en=1, cordic_xin=cur, cordic_yin=0, cordic_angle_in=theta[k].
  - Go to S_WAIT.
- S_WAIT:
  - Hold the core inputs stable until cordic_op_vld.
  - On cordic_op_vld, in the same edge: write w_work per the math above, drive cordic_nrst=0 and cordic_en=0.
  - If k==0, go to S_DONE. Otherwise decrement k and go to S_ISSUE.
  - Each rotation therefore includes at least one cycle with the core in reset before the next S_ISSUE.
- S_DONE, one cycle:
  - Copy w_work to w_out_flat, drive done=1 and busy=0, go to S_IDLE.
  - done returns to 0 on the next cycle.
- w_out_flat holds the previous result for the whole computation. It changes only in S_DONE.
- start while busy=1 is ignored; no queuing. start in the same cycle as S_DONE is also ignored.
- Latency is (N_DIM-1)*(2+L) + 1 cycles from the start edge to the done edge, where L is the core's en-to-valid latency.
- cordic_op_vld outside S_WAIT is ignored.
- Arithmetic is performed only by the core. The block adds no scaling, rounding or saturation.

Optional Feature:
- Macro: THETA_ZERO_SKIP_EN.
- Defined: in S_ISSUE, if theta[k] == 0, the core is not started; cordic_en and cordic_nrst stay 0. The result is taken as xout=cur, yout=0 and written in that cycle, then the FSM advances directly (next S_ISSUE, or S_DONE if k==0). Latency drops by 1+L per zero angle.
- Not defined: every angle, including 0, goes through the core.

Test Plan:
All scenarios use N_DIM=3, DATA_WIDTH=16, and an ideal gain-compensated rotation model with L=4.
1. r_in=0x4000, thetas {0,0}, start pulse -> core sees angle 0 then angle 0. w_out={w0=0, w1=0, w2=0x4000}. done pulses exactly once, 13 cycles after start. busy high in between.
2. r_in=0x4000, theta1=0x4000 (90 deg), theta0=0 -> first issue xin=0x4000, angle=0x4000; second issue xin=0x4000, angle=0. w_out={0x4000, 0, 0} within ±1 LSB.
3. r_in=0x2000, theta1=0x2000 (45 deg), theta0=0x2000 -> w2≈0x16A1, w0≈0x1000, w1≈0x1000 (±2 LSB). Angle issue order is theta1 then theta0.
4. Second start pulse while busy, then another in the S_DONE cycle -> both ignored. Exactly one done. w_out_flat unchanged until S_DONE.
5. nreset pulsed low during the second S_WAIT -> all outputs 0 immediately, no done. A new start after release produces a correct result.
6. With THETA_ZERO_SKIP_EN defined, scenario 1 -> cordic_en never asserts, same w_out, done 3 cycles after start. Without the macro, behaviour is as in scenario 1.
